// File: rtl/win_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : win_detector_pkg
//  Purpose  : Shared constants, FSM state encoding and direction helpers for
//             the five-in-a-row win detector.
//  Contents : cell colour codes, direction codes, state_t, per-direction
//             row/column step deltas.
//  Revision : 1.0  initial release
// ============================================================================
package win_detector_pkg;

  localparam int MAP_N_DEFAULT = 10;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_WHITE = 2'b11;
  localparam logic [1:0] CELL_BLACK = 2'b10;

  localparam logic [1:0] DIR_H = 2'd0;  // (0,+1)
  localparam logic [1:0] DIR_V = 2'd1;  // (+1,0)
  localparam logic [1:0] DIR_D = 2'd2;  // (+1,+1)
  localparam logic [1:0] DIR_A = 2'd3;  // (+1,-1)

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SCAN_POS = 3'd2,
    S_SCAN_NEG = 3'd3,
    S_EVAL     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // Row delta of the positive walk along a direction.
  function automatic logic signed [1:0] dir_row_delta(input logic [1:0] dir);
    return (dir == DIR_H) ? 2'sb00 : 2'sb01;
  endfunction

  // Column delta of the positive walk along a direction.
  function automatic logic signed [1:0] dir_col_delta(input logic [1:0] dir);
    logic signed [1:0] d;
    case (dir)
      DIR_H:   d = 2'sb01;
      DIR_V:   d = 2'sb00;
      DIR_D:   d = 2'sb01;
      default: d = 2'sb11;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/win_detector_if.sv
`default_nettype none
// ============================================================================
//  Module   : win_detector_if
//  Purpose  : Placement/result bundle between the board logic and the win
//             detector.
//  Signals  : board_state (MAP_N*MAP_N*2, cell k at [2k+:2]), place_valid,
//             place_pos[7:0]  -> detector
//             busy, done, win, winner[1:0], win_dir[1:0], game_over
//                             <- detector
//  Modports : master (board side), slave (detector side)
//  Revision : 1.0  initial release
// ============================================================================
interface win_detector_if #(
  parameter int MAP_N = 10
);
  logic [MAP_N*MAP_N*2-1:0] board_state;
  logic                     place_valid;
  logic [7:0]               place_pos;
  logic                     busy;
  logic                     done;
  logic                     win;
  logic [1:0]               winner;
  logic [1:0]               win_dir;
  logic                     game_over;

  modport master (
    output board_state, place_valid, place_pos,
    input  busy, done, win, winner, win_dir, game_over
  );

  modport slave (
    input  board_state, place_valid, place_pos,
    output busy, done, win, winner, win_dir, game_over
  );
endinterface
`default_nettype wire

// File: rtl/win_detector_cell_step.sv
`default_nettype none
// ============================================================================
//  Module   : win_detector_cell_step
//  Purpose  : Combinational single-cell step along one of four directions,
//             with board-edge detection (no wrap between rows).
//  Ports    : row, col   in   current cell
//             dir        in   direction code (H/V/D/A)
//             neg        in   1 = walk opposite to the direction
//             nxt_row, nxt_col out next cell (meaningless when !in_bounds)
//             in_bounds  out  next cell lies on the board
//  Revision : 1.0  initial release
// ============================================================================
module win_detector_cell_step
  import win_detector_pkg::*;
#(
  parameter int MAP_N = 10,
  parameter int RC_W  = 4     // must be >= 3 (MAP_N >= 5)
) (
  input  logic [RC_W-1:0] row,
  input  logic [RC_W-1:0] col,
  input  logic [1:0]      dir,
  input  logic            neg,
  output logic [RC_W-1:0] nxt_row,
  output logic [RC_W-1:0] nxt_col,
  output logic            in_bounds
);
  logic signed [1:0] w_dr;
  logic signed [1:0] w_dc;

  always_comb begin
    w_dr = dir_row_delta(dir);
    w_dc = dir_col_delta(dir);
    if (neg) begin
      w_dr = -w_dr;
      w_dc = -w_dc;
    end
    nxt_row = row + {{(RC_W-2){w_dr[1]}}, w_dr};
    nxt_col = col + {{(RC_W-2){w_dc[1]}}, w_dc};
    // Edge is judged on the current coordinate so the wrapped arithmetic
    // result above is never trusted when the step leaves the board.
    in_bounds = 1'b1;
    if ((w_dr == 2'sb01 && row == RC_W'(MAP_N-1)) || (w_dr == 2'sb11 && row == '0))
      in_bounds = 1'b0;
    if ((w_dc == 2'sb01 && col == RC_W'(MAP_N-1)) || (w_dc == 2'sb11 && col == '0))
      in_bounds = 1'b0;
  end
endmodule
`default_nettype wire

// File: rtl/win_detector.sv
`default_nettype none
// ============================================================================
//  Module   : win_detector
//  Purpose  : Sequential five-in-a-row checker. Each accepted placement is
//             scanned in four directions over a private board snapshot, one
//             cell per cycle; reports win/winner/win_dir and a sticky
//             game_over.
//  Ports    : clk   in  system clock
//             rst   in  synchronous active-high reset
//             bus   win_detector_if.slave (board_state, place_valid,
//                   place_pos in; busy, done, win, winner, win_dir,
//                   game_over out)
//  Config   : WIN_EXACT_FIVE_EN defined -> only runs of exactly RUN_LEN win
//             (overlines rejected); undefined -> runs >= RUN_LEN win.
//  Note     : MAP_N must match the MAP_N of the connected interface.
//  Revision : 1.0  initial release
// ============================================================================
module win_detector
  import win_detector_pkg::*;
#(
  parameter int MAP_N    = 10,
  parameter int RUN_LEN  = 5,
  parameter int STEP_MAX = 5
) (
  input  logic             clk,
  input  logic             rst,
  win_detector_if.slave    bus
);
  localparam int CELLS  = MAP_N * MAP_N;
  localparam int RC_W   = $clog2(MAP_N);
  localparam int IDX_W  = $clog2(CELLS);
  localparam int STEP_W = $clog2(STEP_MAX + 1);

  state_t               r_state;
  logic [2*CELLS-1:0]   r_snap;
  logic [IDX_W-1:0]     r_org_idx;
  logic [RC_W-1:0]      r_org_row;
  logic [RC_W-1:0]      r_org_col;
  logic [RC_W-1:0]      r_cur_row;
  logic [RC_W-1:0]      r_cur_col;
  logic [1:0]           r_colour;
  logic [1:0]           r_dir;
  logic [3:0]           r_run;
  logic [STEP_W-1:0]    r_step;
  logic                 r_hit;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_win;
  logic [1:0]           r_winner;
  logic [1:0]           r_win_dir;
  logic                 r_game_over;

  logic                 w_accept;
  logic [RC_W-1:0]      w_pos_row;
  logic [RC_W-1:0]      w_pos_col;
  logic [1:0]           w_org_cell;
  logic [RC_W-1:0]      w_nxt_row;
  logic [RC_W-1:0]      w_nxt_col;
  logic                 w_in_bounds;
  logic [IDX_W-1:0]     w_rd_idx;
  logic [1:0]           w_nxt_cell;
  logic                 w_match;
  logic                 w_side_end;
  logic                 w_eval_hit;

  assign w_accept  = (r_state == S_IDLE) && bus.place_valid && !r_game_over &&
                     (int'(bus.place_pos) < CELLS);
  assign w_pos_row = RC_W'(int'(bus.place_pos) / MAP_N);
  assign w_pos_col = RC_W'(int'(bus.place_pos) % MAP_N);

  assign w_org_cell = r_snap[{r_org_idx, 1'b0} +: 2];

  win_detector_cell_step #(
    .MAP_N (MAP_N),
    .RC_W  (RC_W)
  ) u_step (
    .row       (r_cur_row),
    .col       (r_cur_col),
    .dir       (r_dir),
    .neg       (r_state == S_SCAN_NEG),
    .nxt_row   (w_nxt_row),
    .nxt_col   (w_nxt_col),
    .in_bounds (w_in_bounds)
  );

  // Off-board steps read cell 0 instead; the result is masked by in_bounds.
  assign w_rd_idx   = w_in_bounds ?
                      IDX_W'(int'(w_nxt_row) * MAP_N + int'(w_nxt_col)) : '0;
  assign w_nxt_cell = r_snap[{w_rd_idx, 1'b0} +: 2];
  assign w_match    = w_in_bounds && (w_nxt_cell == r_colour);
  // A matching step that uses up the step budget also closes the side, so a
  // side never costs more than STEP_MAX cycles.
  assign w_side_end = !w_match || (r_step == STEP_W'(STEP_MAX - 1));

`ifdef WIN_EXACT_FIVE_EN
  assign w_eval_hit = (r_run == 4'(RUN_LEN));
`else
  assign w_eval_hit = (r_run >= 4'(RUN_LEN));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_snap      <= '0;
      r_org_idx   <= '0;
      r_org_row   <= '0;
      r_org_col   <= '0;
      r_cur_row   <= '0;
      r_cur_col   <= '0;
      r_colour    <= CELL_EMPTY;
      r_dir       <= DIR_H;
      r_run       <= '0;
      r_step      <= '0;
      r_hit       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_win       <= 1'b0;
      r_winner    <= 2'b00;
      r_win_dir   <= 2'b00;
      r_game_over <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_snap    <= bus.board_state;
            r_org_idx <= IDX_W'(bus.place_pos);
            r_org_row <= w_pos_row;
            r_org_col <= w_pos_col;
            r_hit     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_colour  <= w_org_cell;
          r_dir     <= DIR_H;
          r_run     <= 4'd1;
          r_step    <= '0;
          r_cur_row <= r_org_row;
          r_cur_col <= r_org_col;
          r_state   <= (w_org_cell == CELL_EMPTY) ? S_DONE : S_SCAN_POS;
        end

        S_SCAN_POS, S_SCAN_NEG: begin
          if (w_match) begin
            r_run     <= (r_run == 4'hF) ? r_run : r_run + 4'd1;
            r_cur_row <= w_nxt_row;
            r_cur_col <= w_nxt_col;
            r_step    <= r_step + STEP_W'(1);
          end
          if (w_side_end) begin
            r_cur_row <= r_org_row;
            r_cur_col <= r_org_col;
            r_step    <= '0;
            r_state   <= (r_state == S_SCAN_POS) ? S_SCAN_NEG : S_EVAL;
          end
        end

        S_EVAL: begin
          if (w_eval_hit) begin
            r_hit     <= 1'b1;
            r_win_dir <= r_dir;
            r_state   <= S_DONE;
          end else if (r_dir == DIR_A) begin
            r_state   <= S_DONE;
          end else begin
            r_dir     <= r_dir + 2'd1;
            r_run     <= 4'd1;
            r_state   <= S_SCAN_POS;
          end
        end

        S_DONE: begin
          r_done <= 1'b1;
          r_win  <= r_hit;
          if (r_hit) begin
            r_winner    <= r_colour;
            r_game_over <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.win       = r_win;
  assign bus.winner    = r_winner;
  assign bus.win_dir   = r_win_dir;
  assign bus.game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_win_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_win_detector
//  Purpose  : Self-checking bench for win_detector: directed scenarios plus
//             random boards compared against a behavioural line-count model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_win_detector;
  localparam int N        = 10;
  localparam int CELLS    = N * N;
  localparam int BW       = 2 * CELLS;
  localparam int RUN_LEN  = 5;
  localparam int STEP_MAX = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   DR[4] = '{0, 1, 1, 1};
  int   DC[4] = '{1, 0, 1, -1};

  win_detector_if #(.MAP_N(N)) bus ();

  win_detector #(
    .MAP_N    (N),
    .RUN_LEN  (RUN_LEN),
    .STEP_MAX (STEP_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- board helpers and reference model ----------------
  function automatic logic [1:0] cell_of(input logic [BW-1:0] b, input int r, input int c);
    return b[2*(r*N+c) +: 2];
  endfunction

  function automatic logic [BW-1:0] with_cell(input logic [BW-1:0] b, input int pos,
                                              input logic [1:0] v);
    logic [BW-1:0] t;
    t = b;
    t[2*pos +: 2] = v;
    return t;
  endfunction

  function automatic logic [BW-1:0] rand_board(input int pct);
    logic [BW-1:0] t;
    t = '0;
    for (int k = 0; k < CELLS; k++)
      if ($urandom_range(0, 99) < pct)
        t[2*k +: 2] = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
    return t;
  endfunction

  function automatic bit rule_hit(input int run);
`ifdef WIN_EXACT_FIVE_EN
    return run == RUN_LEN;
`else
    return run >= RUN_LEN;
`endif
  endfunction

  // Counts same-colour stones on each side of pos per direction and
  // predicts the result and the accept-to-done latency.
  task automatic model(input logic [BW-1:0] b, input int pos, output bit hit,
                       output int hdir, output logic [1:0] col, output int lat);
    int r0, c0, run, k, rr, cc, sg;
    r0 = pos / N;
    c0 = pos % N;
    col = cell_of(b, r0, c0);
    hit = 0;
    hdir = 0;
    lat = 3;
    if (col == 2'b00) return;
    for (int d = 0; d < 4; d++) begin
      run = 1;
      for (int s = 0; s < 2; s++) begin
        sg = (s == 0) ? 1 : -1;
        k = 0;
        while (k < STEP_MAX) begin
          rr = r0 + sg * DR[d] * (k + 1);
          cc = c0 + sg * DC[d] * (k + 1);
          if (rr < 0 || rr >= N || cc < 0 || cc >= N) break;
          if (cell_of(b, rr, cc) != col) break;
          k++;
        end
        run += k;
        lat += (k < STEP_MAX) ? k + 1 : STEP_MAX;
      end
      lat += 1;
      if (rule_hit(run)) begin
        hit = 1;
        hdir = d;
        return;
      end
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.place_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Pulses a placement, optionally scrambles the live board after accept,
  // waits (bounded) for done. lat counts cycles from the accept cycle.
  task automatic place(input int pos, input bit scramble, output bit got, output int lat);
    @(posedge clk); #1;
    bus.place_pos   = 8'(pos);
    bus.place_valid = 1'b1;
    @(posedge clk); #1;
    bus.place_valid = 1'b0;
    bus.place_pos   = 8'd0;
    if (scramble) bus.board_state = rand_board(60);
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    got = bus.done;
  endtask

  task automatic count_done(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (bus.done) cnt++;
    end
  endtask

  function automatic logic [BW-1:0] line_board(input int first, input int stride,
                                               input int len, input logic [1:0] v);
    logic [BW-1:0] t;
    t = '0;
    for (int k = 0; k < len; k++) t[2*(first + k*stride) +: 2] = v;
    return t;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.board_state = rand_board(50);
    bus.place_valid = 1'b0;
    bus.place_pos   = 8'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", bus.done); end
    n_checks++; if (bus.win !== 1'b0) begin n_fail++; $display("FAIL rst_win got %b want 0", bus.win); end
    n_checks++; if (bus.winner !== 2'b00) begin n_fail++; $display("FAIL rst_winner got %b want 00", bus.winner); end
    n_checks++; if (bus.win_dir !== 2'b00) begin n_fail++; $display("FAIL rst_win_dir got %0d want 0", bus.win_dir); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL rst_game_over got %b want 0", bus.game_over); end
  endtask

  task automatic test_horizontal();
    bit got, mh; int lat, md, ml, cnt; logic [1:0] mc;
    do_reset();
    bus.board_state = line_board(40, 1, 5, 2'b11);
    model(bus.board_state, 42, mh, md, mc, ml);
    place(42, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL h_done timeout after %0d cycles", lat); end
    n_checks++; if (bus.win !== 1'b1) begin n_fail++; $display("FAIL h_win got %b want 1", bus.win); end
    n_checks++; if (bus.winner !== 2'b11) begin n_fail++; $display("FAIL h_winner got %b want 11", bus.winner); end
    n_checks++; if (bus.win_dir !== 2'd0) begin n_fail++; $display("FAIL h_dir got %0d want 0", bus.win_dir); end
    n_checks++; if (bus.game_over !== 1'b1) begin n_fail++; $display("FAIL h_game_over got %b want 1", bus.game_over); end
    n_checks++; if (lat != ml) begin n_fail++; $display("FAIL h_latency got %0d want %0d", lat, ml); end
    // game_over blocks a later accept; results hold
    bus.board_state = line_board(60, 1, 5, 2'b10);
    @(posedge clk); #1; bus.place_pos = 8'd62; bus.place_valid = 1'b1;
    @(posedge clk); #1; bus.place_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL go_block_busy got %b want 0", bus.busy); end
    count_done(30, cnt);
    n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL go_block_done got %0d pulses want 0", cnt); end
    n_checks++; if (bus.winner !== 2'b11) begin n_fail++; $display("FAIL go_hold_winner got %b want 11", bus.winner); end
  endtask

  task automatic test_vertical();
    bit got; int lat;
    do_reset();
    bus.board_state = line_board(9, 10, 4, 2'b10);
    place(39, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL v4_done timeout after %0d cycles", lat); end
    n_checks++; if (bus.win !== 1'b0) begin n_fail++; $display("FAIL v4_win got %b want 0", bus.win); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL v4_game_over got %b want 0", bus.game_over); end
    bus.board_state = with_cell(bus.board_state, 49, 2'b10);
    place(49, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL v5_done timeout after %0d cycles", lat); end
    n_checks++; if (bus.win !== 1'b1) begin n_fail++; $display("FAIL v5_win got %b want 1", bus.win); end
    n_checks++; if (bus.win_dir !== 2'd1) begin n_fail++; $display("FAIL v5_dir got %0d want 1", bus.win_dir); end
    n_checks++; if (bus.winner !== 2'b10) begin n_fail++; $display("FAIL v5_winner got %b want 10", bus.winner); end
  endtask

  task automatic test_diagonals();
    bit got; int lat;
    do_reset();
    bus.board_state = line_board(0, 11, 5, 2'b11);
    place(0, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL d_done timeout after %0d cycles", lat); end
    n_checks++; if (bus.win !== 1'b1) begin n_fail++; $display("FAIL d_win got %b want 1", bus.win); end
    n_checks++; if (bus.win_dir !== 2'd2) begin n_fail++; $display("FAIL d_dir got %0d want 2", bus.win_dir); end
    do_reset();
    bus.board_state = line_board(9, 9, 5, 2'b11);
    place(9, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL a_done timeout after %0d cycles", lat); end
    n_checks++; if (bus.win !== 1'b1) begin n_fail++; $display("FAIL a_win got %b want 1", bus.win); end
    n_checks++; if (bus.win_dir !== 2'd3) begin n_fail++; $display("FAIL a_dir got %0d want 3", bus.win_dir); end
  endtask

  task automatic test_edges();
    bit got, mh, exp_win; int lat, md, ml, cnt; logic [1:0] mc;
    // row wrap must not join row 0 and row 1
    do_reset();
    bus.board_state = line_board(7, 1, 5, 2'b11);
    model(bus.board_state, 9, mh, md, mc, ml);
    place(9, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL wrap_done timeout after %0d cycles", lat); end
    n_checks++; if (bus.win !== 1'b0) begin n_fail++; $display("FAIL wrap_win got %b want 0", bus.win); end
    n_checks++; if (lat != ml) begin n_fail++; $display("FAIL wrap_latency got %0d want %0d", lat, ml); end
    // overline
    do_reset();
    bus.board_state = line_board(50, 1, 6, 2'b11);
`ifdef WIN_EXACT_FIVE_EN
    exp_win = 1'b0;
`else
    exp_win = 1'b1;
`endif
    place(52, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL over_done timeout after %0d cycles", lat); end
    n_checks++; if (bus.win !== exp_win) begin n_fail++; $display("FAIL over_win got %b want %b", bus.win, exp_win); end
    // empty origin finishes straight after LOAD
    do_reset();
    bus.board_state = '0;
    place(55, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL empty_done timeout after %0d cycles", lat); end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL empty_latency got %0d want 3", lat); end
    n_checks++; if (bus.win !== 1'b0) begin n_fail++; $display("FAIL empty_win got %b want 0", bus.win); end
    // out-of-range position is dropped
    bus.board_state = line_board(40, 1, 5, 2'b11);
    @(posedge clk); #1; bus.place_pos = 8'd100; bus.place_valid = 1'b1;
    @(posedge clk); #1; bus.place_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL oor_busy got %b want 0", bus.busy); end
    count_done(30, cnt);
    n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL oor_done got %0d pulses want 0", cnt); end
  endtask

  task automatic test_busy_and_abort();
    bit got; int lat, cnt;
    do_reset();
    bus.board_state = with_cell('0, 44, 2'b11);
    place(44, 1'b0, got, lat);
    n_checks++; if (!got) begin n_fail++; $display("FAIL lone_done timeout after %0d cycles", lat); end
    n_checks++; if (lat != 15) begin n_fail++; $display("FAIL lone_latency got %0d want 15", lat); end
    // placement while busy is ignored
    @(posedge clk); #1; bus.place_pos = 8'd44; bus.place_valid = 1'b1;
    @(posedge clk); #1; bus.place_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL scan_busy got %b want 1", bus.busy); end
    bus.board_state = line_board(40, 1, 5, 2'b11);
    bus.place_pos = 8'd42; bus.place_valid = 1'b1;
    @(posedge clk); #1; bus.place_valid = 1'b0;
    count_done(40, cnt);
    n_checks++; if (cnt != 1) begin n_fail++; $display("FAIL busy_ignore got %0d done pulses want 1", cnt); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_go got %b want 0", bus.game_over); end
    // reset mid-scan on a winning board aborts without done
    @(posedge clk); #1; bus.place_pos = 8'd42; bus.place_valid = 1'b1;
    @(posedge clk); #1; bus.place_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    count_done(30, cnt);
    n_checks++; if (cnt != 0) begin n_fail++; $display("FAIL abort_done got %0d pulses want 0", cnt); end
    n_checks++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL abort_game_over got %b want 0", bus.game_over); end
  endtask

  task automatic test_random();
    bit got, mh; int lat, md, ml, pos, r0, c0, len, d, off, rr, cc;
    logic [1:0] mc, colour;
    logic [BW-1:0] b;
    for (int it = 0; it < 60; it++) begin
      do_reset();
      b = rand_board($urandom_range(20, 70));
      pos = $urandom_range(0, CELLS - 1);
      r0 = pos / N; c0 = pos % N;
      colour = ($urandom_range(0, 9) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
      if (colour != 2'b00 && $urandom_range(0, 1) == 1) begin
        len = $urandom_range(3, 8); d = $urandom_range(0, 3); off = $urandom_range(0, len - 1);
        for (int k = 0; k < len; k++) begin
          rr = r0 + (k - off) * DR[d];
          cc = c0 + (k - off) * DC[d];
          if (rr >= 0 && rr < N && cc >= 0 && cc < N) b = with_cell(b, rr*N + cc, colour);
        end
      end
      b = with_cell(b, pos, colour);
      bus.board_state = b;
      model(b, pos, mh, md, mc, ml);
      place(pos, 1'b1, got, lat);
      n_checks++; if (!got) begin n_fail++; $display("FAIL rnd%0d_done timeout after %0d cycles", it, lat); end
      n_checks++; if (bus.win !== mh) begin n_fail++; $display("FAIL rnd%0d_win pos %0d got %b want %b", it, pos, bus.win, mh); end
      n_checks++; if (lat != ml) begin n_fail++; $display("FAIL rnd%0d_latency pos %0d got %0d want %0d", it, pos, lat, ml); end
      n_checks++; if (bus.game_over !== mh) begin n_fail++; $display("FAIL rnd%0d_game_over got %b want %b", it, bus.game_over, mh); end
      if (mh) begin
        n_checks++; if (bus.win_dir !== 2'(md)) begin n_fail++; $display("FAIL rnd%0d_dir got %0d want %0d", it, bus.win_dir, md); end
        n_checks++; if (bus.winner !== mc) begin n_fail++; $display("FAIL rnd%0d_winner got %b want %b", it, bus.winner, mc); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.board_state = '0;
    bus.place_valid = 1'b0;
    bus.place_pos   = 8'd0;
    test_reset();
    test_horizontal();
    test_vertical();
    test_diagonals();
    test_edges();
    test_busy_and_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
